// File: rtl/state_register_bank_pkg.sv
// Shared types for the state register bank: operation encoding, default
// geometry and the legacy fixed-size state type.
package state_register_bank_pkg;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_XOR   = 2'd2,
        OP_CLEAR = 2'd3
    } state_op_t;

    localparam int unsigned DefNbWords = 5;
    localparam int unsigned DefWordW   = 64;
    localparam int unsigned DefCntW    = 4;

    // Legacy ASCON-128 state type; matches the bank at its default geometry.
    typedef logic [DefNbWords-1:0][DefWordW-1:0] type_state;

    // LOAD and XOR are the operations that count as updates.
    function automatic logic is_update(input state_op_t op);
        return (op == OP_LOAD) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/state_register_bank_if.sv
// Request/response bundle of the state register bank. The master side issues
// operations and consumes the state; the slave side is the bank itself.
interface state_register_bank_if
    import state_register_bank_pkg::*;
#(
    parameter int unsigned NB_WORDS = 5,
    parameter int unsigned WORD_W   = 64,
    parameter int unsigned CNT_W    = 4
);
    logic                             valid_i;
    logic                             ready_o;
    state_op_t                        op_i;
    logic [NB_WORDS-1:0]              mask_i;
    logic [NB_WORDS-1:0][WORD_W-1:0]  data_i;
    logic [NB_WORDS-1:0][WORD_W-1:0]  data_o;
    logic                             valid_o;
    logic                             ready_i;
    logic [CNT_W-1:0]                 upd_cnt_o;

    modport master (
        output valid_i, op_i, mask_i, data_i, ready_i,
        input  ready_o, data_o, valid_o, upd_cnt_o
    );

    modport slave (
        input  valid_i, op_i, mask_i, data_i, ready_i,
        output ready_o, data_o, valid_o, upd_cnt_o
    );
endinterface

// File: rtl/state_register_bank_state_word_reg.sv
// One state word: load, XOR-absorb or clear when enabled, otherwise hold.
module state_word_reg
    import state_register_bank_pkg::*;
#(
    parameter int unsigned WORD_W = 64
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              en_i,
    input  state_op_t         op_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] q_o
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    // Next-state word value for the enabled operation.
    always_comb begin
        word_d = word_q;
        if (en_i) begin
            unique case (op_i)
                OP_LOAD:  word_d = data_i;
                OP_XOR:   word_d = word_q ^ data_i;
                OP_CLEAR: word_d = '0;
                OP_HOLD:  word_d = word_q;
            endcase
        end
    end

    // Word storage with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/state_register_bank.sv
// NB_WORDS x WORD_W state bank with masked LOAD/XOR/CLEAR, a one-slot
// valid/ready output stage and a saturating update counter.
module state_register_bank
    import state_register_bank_pkg::*;
#(
    parameter int unsigned NB_WORDS = 5,
    parameter int unsigned WORD_W   = 64,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    state_register_bank_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic                            valid_q;
    logic                            valid_d;
    logic [CNT_W-1:0]                cnt_q;
    logic [CNT_W-1:0]                cnt_d;
    logic                            ready;
    logic                            accept;
    logic [NB_WORDS-1:0]             word_en;
    logic [NB_WORDS-1:0][WORD_W-1:0] words;

    // Input is accepted whenever the output slot is empty or draining now.
    always_comb begin
        ready  = !valid_q || bus.ready_i;
        accept = bus.valid_i && ready;
    end

    // CLEAR hits every word; LOAD/XOR only the masked ones.
    always_comb begin
        word_en = '0;
        for (int k = 0; k < NB_WORDS; k++) begin
            word_en[k] = accept &&
                         ((bus.op_i == OP_CLEAR) || (is_update(bus.op_i) && bus.mask_i[k]));
        end
    end

    for (genvar k = 0; k < NB_WORDS; k++) begin : g_word
        state_word_reg #(
            .WORD_W (WORD_W)
        ) u_word (
            .clock_i  (clock_i),
            .resetb_i (resetb_i),
            .en_i     (word_en[k]),
            .op_i     (bus.op_i),
            .data_i   (bus.data_i[k]),
            .q_o      (words[k])
        );
    end

    // A new non-HOLD update wins over draining the previous one.
    always_comb begin
        valid_d = valid_q;
        if (accept && (bus.op_i != OP_HOLD)) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Update counter: saturating increment, cleared by CLEAR.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (bus.op_i == OP_CLEAR) begin
                cnt_d = '0;
            end else if (is_update(bus.op_i) && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Handshake flag and counter registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready_o   = ready;
    assign bus.valid_o   = valid_q;
    assign bus.upd_cnt_o = cnt_q;
    assign bus.data_o    = words;

endmodule
